buffer: RTL and testbench
=========================

BUFFER -- requirements
Module: buffer

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the byte width of d and of each stored byte.
REQ-002 Parameter NBYTES, default 4, SHALL set the bytes per frame; z width 3 and joi width 32 SHALL hold for the defaults.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
REQ-005 tick  input  1  byte-valid strobe from the PS/2 receiver; a 0->1 transition marks d valid.
REQ-006 d  input  8  received byte.
REQ-007 ready  output  1  buffer can accept a byte (not full).
REQ-008 qfi  output  8  first stored byte.
REQ-009 qs  output  8  second stored byte.
REQ-010 qt  output  8  third stored byte.
REQ-011 qf  output  8  fourth stored byte.
REQ-012 z  output  3  count of bytes stored in the current frame, 0..4.
REQ-013 joi  output  32  assembled frame {qfi,qs,qt,qf}, first byte in bits 31:24.
REQ-014 listo  output  1  frame-complete pulse.

Function
REQ-015 tick SHALL be registered (tick_q) each clk; a capture event SHALL be tick==1 && tick_q==0 on a clk rising edge.
REQ-016 On a capture event with z<4: d SHALL be written to byte slot z (0->qfi, 1->qs, 2->qt, 3->qf) and z SHALL increment by 1 on the same edge.
REQ-017 tick held high SHALL produce exactly one capture; d is sampled only at the capture edge.
REQ-018 On the edge where z goes 3->4: joi SHALL load {qfi,qs,qt,d} and listo SHALL be 1 for exactly the following cycle.
REQ-019 While z==4 (FULL), ready SHALL be 0 and capture events SHALL be ignored (byte dropped, no register change).
REQ-020 On the cycle after FULL, z SHALL return to 0 (wrap); qfi..qf and joi SHALL hold until overwritten; listo returns to 0.
REQ-021 ready SHALL be combinational: ready = (z != 4).
REQ-022 States: EMPTY (z=0), FILLING (z=1..3), FULL (z=4, one cycle); transitions only as in REQ-016 to REQ-020.
REQ-023 joi SHALL change only at the 3->4 transition, never during partial frames.

Reset
REQ-024 With reset==0 at a clk edge: z=0, qfi=qs=qt=qf=0, joi=0, listo=0, tick_q=0; ready therefore reads 1.
REQ-025 Reset SHALL take priority over a simultaneous capture; a partial frame SHALL be discarded.
REQ-026 After release, a tick already high SHALL count as a capture at the first edge (tick_q reset to 0).

Structure
REQ-027 A shared package buffer_pkg SHALL hold DATA_W, NBYTES, FRAME_W=32 and the state enum {EMPTY, FILLING, FULL}.
REQ-028 One sub-module, tick_edge_detect (registers tick and outputs a 1-cycle rise pulse), SHALL be instantiated.

Verification
REQ-029 Reset low 2 cycles -> z=0, all bytes 0, joi=0, listo=0, ready=1.
REQ-030 Captures of 8'h10, 8'h01, 8'h11, 8'h10 -> qfi=10, qs=01, qt=11, qf=10, joi=32'h10011110, listo high exactly 1 cycle, z then 0.
REQ-031 tick held high 5 cycles with d changing -> only the first d stored, z increments by 1.
REQ-032 Capture event in the FULL cycle -> byte ignored, z goes 4->0, joi unchanged.
REQ-033 Reset asserted after 2 captures -> z=0, bytes cleared; next 4 captures form a new frame starting at qfi.
REQ-034 Two consecutive frames (AA,BB,CC,DD then 01,02,03,04) -> joi=32'hAABBCCDD then 32'h01020304, one listo pulse per frame.

Source files
------------

// File: rtl/buffer_pkg.sv
// Shared constants and state encoding for the PS/2 byte-to-frame buffer.
package buffer_pkg;
    localparam int DATA_W  = 8;
    localparam int NBYTES  = 4;
    localparam int FRAME_W = 32;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } state_t;
endpackage

// File: rtl/buffer_tick_edge_detect.sv
// Registers tick and emits a one-cycle pulse on its rising edge (combinational from the registered copy).
module tick_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_tick,
    output logic o_rise
);
    logic r_tick_q;

    always_ff @(posedge clk) begin
        if (!reset) r_tick_q <= 1'b0;
        else        r_tick_q <= i_tick;
    end

    // Clearing r_tick_q in reset lets a tick already high at release count as a capture.
    assign o_rise = i_tick & ~r_tick_q;
endmodule

// File: rtl/buffer.sv
// Assembles NBYTES received bytes into a frame; joi/listo update when the last byte lands.
// Bytes arriving during the single FULL cycle are dropped; ready reflects that.
module buffer
    import buffer_pkg::*;
#(
    parameter int DATA_W = buffer_pkg::DATA_W,
    parameter int NBYTES = buffer_pkg::NBYTES,
    parameter int Z_W    = $clog2(NBYTES + 1),
    parameter int FW     = DATA_W * NBYTES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [DATA_W-1:0] d,
    output logic              ready,
    output logic [DATA_W-1:0] qfi,
    output logic [DATA_W-1:0] qs,
    output logic [DATA_W-1:0] qt,
    output logic [DATA_W-1:0] qf,
    output logic [Z_W-1:0]    z,
    output logic [FW-1:0]     joi,
    output logic              listo
);
    localparam logic [Z_W-1:0] Z_FULL = Z_W'(NBYTES);
    localparam logic [Z_W-1:0] Z_LAST = Z_W'(NBYTES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [Z_W-1:0]    r_z;
    logic [DATA_W-1:0] r_bytes [NBYTES];
    logic [FW-1:0]     r_joi;
    logic              w_rise;
    logic              w_store;

    tick_edge_detect u_edge (
        .clk    (clk),
        .reset  (reset),
        .i_tick (tick),
        .o_rise (w_rise)
    );

    assign w_store = w_rise && (r_state != FULL);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY, FILLING: if (w_store) w_state_nxt = (r_z == Z_LAST) ? FULL : FILLING;
            FULL:           w_state_nxt = EMPTY;
            default:        w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= EMPTY;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_z   <= '0;
            r_joi <= '0;
            for (int i = 0; i < NBYTES; i++) r_bytes[i] <= '0;
        end else if (r_state == FULL) begin
            r_z <= '0;
        end else if (w_store) begin
            r_z <= r_z + 1'b1;
            for (int i = 0; i < NBYTES; i++)
                if (r_z == Z_W'(i)) r_bytes[i] <= d;
            // The last byte is taken from d directly so joi is complete on the same edge.
            if (r_z == Z_LAST) begin
                for (int i = 0; i < NBYTES - 1; i++)
                    r_joi[FW-1-i*DATA_W -: DATA_W] <= r_bytes[i];
                r_joi[DATA_W-1:0] <= d;
            end
        end
    end

    assign ready = (r_z != Z_FULL);
    assign listo = (r_state == FULL);
    assign z     = r_z;
    assign joi   = r_joi;
    assign qfi   = r_bytes[0];
    assign qs    = r_bytes[1];
    assign qt    = r_bytes[2];
    assign qf    = r_bytes[3];
endmodule

// File: tb/tb_buffer.sv
// Directed bench for buffer: reset, frame assembly, held tick, FULL cycle, mid-frame reset, back-to-back frames.
module tb_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic [7:0]  d = 8'h00;
    logic        ready;
    logic [7:0]  qfi, qs, qt, qf;
    logic [2:0]  z;
    logic [31:0] joi;
    logic        listo;

    int n_checks = 0;
    int n_fail   = 0;
    int listo_cnt = 0;

    always #5 clk = ~clk;

    buffer dut (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .d     (d),
        .ready (ready),
        .qfi   (qfi),
        .qs    (qs),
        .qt    (qt),
        .qf    (qf),
        .z     (z),
        .joi   (joi),
        .listo (listo)
    );

    task automatic step();
        @(posedge clk);
        #1;
        if (listo) listo_cnt++;
    endtask

    task automatic do_capture(input logic [7:0] b);
        tick = 1'b1;
        d    = b;
        step();
        tick = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick  = 1'b0;
        step();
        step();
        n_checks++; if (z !== 3'd0) begin n_fail++; $display("FAIL reset_z got %0d exp 0", z); end
        n_checks++; if ({qfi, qs, qt, qf} !== 32'h0) begin n_fail++; $display("FAIL reset_bytes got %h exp 00000000", {qfi, qs, qt, qf}); end
        n_checks++; if (joi !== 32'h0) begin n_fail++; $display("FAIL reset_joi got %h exp 00000000", joi); end
        n_checks++; if (listo !== 1'b0) begin n_fail++; $display("FAIL reset_listo got %b exp 0", listo); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", ready); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_frame();
        listo_cnt = 0;
        do_capture(8'h10);
        n_checks++; if (z !== 3'd1) begin n_fail++; $display("FAIL frame_z1 got %0d exp 1", z); end
        do_capture(8'h01);
        do_capture(8'h11);
        n_checks++; if (z !== 3'd3) begin n_fail++; $display("FAIL frame_z3 got %0d exp 3", z); end
        n_checks++; if (joi !== 32'h0) begin n_fail++; $display("FAIL frame_joi_partial got %h exp 00000000", joi); end
        tick = 1'b1;
        d    = 8'h10;
        step();
        n_checks++; if (z !== 3'd4) begin n_fail++; $display("FAIL frame_z4 got %0d exp 4", z); end
        n_checks++; if (listo !== 1'b1) begin n_fail++; $display("FAIL frame_listo_hi got %b exp 1", listo); end
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL frame_ready_full got %b exp 0", ready); end
        n_checks++; if (joi !== 32'h10011110) begin n_fail++; $display("FAIL frame_joi got %h exp 10011110", joi); end
        tick = 1'b0;
        step();
        n_checks++; if (listo !== 1'b0) begin n_fail++; $display("FAIL frame_listo_lo got %b exp 0", listo); end
        n_checks++; if (z !== 3'd0) begin n_fail++; $display("FAIL frame_wrap got %0d exp 0", z); end
        n_checks++; if ({qfi, qs, qt, qf} !== 32'h10011110) begin n_fail++; $display("FAIL frame_bytes got %h exp 10011110", {qfi, qs, qt, qf}); end
        n_checks++; if (joi !== 32'h10011110) begin n_fail++; $display("FAIL frame_joi_hold got %h exp 10011110", joi); end
        n_checks++; if (listo_cnt !== 1) begin n_fail++; $display("FAIL frame_listo_pulses got %0d exp 1", listo_cnt); end
    endtask

    task automatic test_tick_held();
        tick = 1'b1;
        d    = 8'h55;
        step();
        for (int i = 0; i < 4; i++) begin
            d = 8'h66 + 8'(i);
            step();
        end
        tick = 1'b0;
        step();
        n_checks++; if (z !== 3'd1) begin n_fail++; $display("FAIL held_z got %0d exp 1", z); end
        n_checks++; if (qfi !== 8'h55) begin n_fail++; $display("FAIL held_qfi got %h exp 55", qfi); end
        n_checks++; if (qs !== 8'h01) begin n_fail++; $display("FAIL held_qs got %h exp 01", qs); end
    endtask

    task automatic test_full_drop();
        do_capture(8'hA1);
        do_capture(8'hA2);
        tick = 1'b1;
        d    = 8'hA3;
        step();
        n_checks++; if (joi !== 32'h55A1A2A3) begin n_fail++; $display("FAIL full_joi got %h exp 55A1A2A3", joi); end
        d = 8'hEE;
        step();
        n_checks++; if (z !== 3'd0) begin n_fail++; $display("FAIL full_wrap got %0d exp 0", z); end
        n_checks++; if (joi !== 32'h55A1A2A3) begin n_fail++; $display("FAIL full_joi_hold got %h exp 55A1A2A3", joi); end
        n_checks++; if ({qfi, qf} !== 16'h55A3) begin n_fail++; $display("FAIL full_drop_bytes got %h exp 55A3", {qfi, qf}); end
        tick = 1'b0;
        step();
        n_checks++; if (z !== 3'd0) begin n_fail++; $display("FAIL full_after_z got %0d exp 0", z); end
    endtask

    task automatic test_reset_mid();
        do_capture(8'h21);
        do_capture(8'h22);
        n_checks++; if (z !== 3'd2) begin n_fail++; $display("FAIL mid_z_pre got %0d exp 2", z); end
        reset = 1'b0;
        tick  = 1'b1;
        d     = 8'h99;
        step();
        n_checks++; if (z !== 3'd0) begin n_fail++; $display("FAIL mid_z got %0d exp 0", z); end
        n_checks++; if ({qfi, qs, joi} !== 48'h0) begin n_fail++; $display("FAIL mid_clear got %h exp 0", {qfi, qs, joi}); end
        reset = 1'b1;
        d     = 8'h31;
        step();
        n_checks++; if ({z, qfi} !== {3'd1, 8'h31}) begin n_fail++; $display("FAIL mid_release_capture got z=%0d qfi=%h exp z=1 qfi=31", z, qfi); end
        tick = 1'b0;
        step();
        do_capture(8'h32);
        do_capture(8'h33);
        listo_cnt = 0;
        do_capture(8'h34);
        n_checks++; if (joi !== 32'h31323334) begin n_fail++; $display("FAIL mid_newframe got %h exp 31323334", joi); end
        n_checks++; if (listo_cnt !== 1) begin n_fail++; $display("FAIL mid_listo_pulses got %0d exp 1", listo_cnt); end
    endtask

    task automatic test_back_to_back();
        listo_cnt = 0;
        do_capture(8'hAA);
        do_capture(8'hBB);
        do_capture(8'hCC);
        do_capture(8'hDD);
        n_checks++; if (joi !== 32'hAABBCCDD) begin n_fail++; $display("FAIL b2b_joi1 got %h exp AABBCCDD", joi); end
        n_checks++; if (listo_cnt !== 1) begin n_fail++; $display("FAIL b2b_listo1 got %0d exp 1", listo_cnt); end
        do_capture(8'h01);
        do_capture(8'h02);
        do_capture(8'h03);
        n_checks++; if (joi !== 32'hAABBCCDD) begin n_fail++; $display("FAIL b2b_joi_partial got %h exp AABBCCDD", joi); end
        do_capture(8'h04);
        n_checks++; if (joi !== 32'h01020304) begin n_fail++; $display("FAIL b2b_joi2 got %h exp 01020304", joi); end
        n_checks++; if (listo_cnt !== 2) begin n_fail++; $display("FAIL b2b_listo2 got %0d exp 2", listo_cnt); end
        n_checks++; if ({z, ready} !== {3'd0, 1'b1}) begin n_fail++; $display("FAIL b2b_idle got z=%0d ready=%b exp z=0 ready=1", z, ready); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_tick_held();
        test_full_drop();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
